// File: rtl/mux_stream_arbiter_if.sv
// rtl/mux_stream_arbiter_if.sv - two-input packet arbiter stream and status bundle
// master: the producers/consumer around the arbiter; slave: the arbiter itself.
interface mux_stream_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              in0_valid;
   logic [DATA_W-1:0] in0_data;
   logic              in0_last;
   logic              in0_ready;
   logic              in1_valid;
   logic [DATA_W-1:0] in1_data;
   logic              in1_last;
   logic              in1_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;
   logic              sel;
   logic              busy;

   modport master (
      output in0_valid, in0_data, in0_last,
      output in1_valid, in1_data, in1_last,
      output out_ready,
      input  in0_ready, in1_ready,
      input  out_valid, out_data, out_last,
      input  sel, busy
   );

   modport slave (
      input  in0_valid, in0_data, in0_last,
      input  in1_valid, in1_data, in1_last,
      input  out_ready,
      output in0_ready, in1_ready,
      output out_valid, out_data, out_last,
      output sel, busy
   );
endinterface

// File: rtl/mux_stream_arbiter.sv
// rtl/mux_stream_arbiter.sv - two-input round-robin packet arbiter with registered output
// Define MUX_STREAM_ARB_FIXED_PRIO_EN for fixed priority (input 0 always wins contention).
module mux_stream_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   mux_stream_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
`ifndef MUX_STREAM_ARB_FIXED_PRIO_EN
   logic              last_grant_q, last_grant_d;
`endif

   logic out_free;
   logic in0_ready, in1_ready;
   logic acc0, acc1;
   logic pick1;

   // Readiness depends only on state and the output register, never on in*_valid.
   always_comb begin
      out_free  = !out_valid_q || bus.out_ready;
      in0_ready = (state_q == LOCK0) && out_free;
      in1_ready = (state_q == LOCK1) && out_free;
      acc0      = bus.in0_valid && in0_ready;
      acc1      = bus.in1_valid && in1_ready;
   end

   always_comb begin
      pick1 = 1'b0;
`ifdef MUX_STREAM_ARB_FIXED_PRIO_EN
      pick1 = bus.in1_valid && !bus.in0_valid;
`else
      // On contention the input that did not finish the previous packet wins.
      pick1 = bus.in1_valid && (!bus.in0_valid || !last_grant_q);
`endif
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      busy_d       = busy_q;
`ifndef MUX_STREAM_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.in0_valid || bus.in1_valid) begin
               state_d = pick1 ? LOCK1 : LOCK0;
               sel_d   = pick1;
               busy_d  = 1'b1;
            end
         end
         LOCK0: begin
            if (acc0 && bus.in0_last) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
`ifndef MUX_STREAM_ARB_FIXED_PRIO_EN
               last_grant_d = 1'b0;
`endif
            end
         end
         LOCK1: begin
            if (acc1 && bus.in1_last) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
`ifndef MUX_STREAM_ARB_FIXED_PRIO_EN
               last_grant_d = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Output register: load on accept, drain on out_ready, otherwise hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (acc0) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in0_data;
         out_last_d  = bus.in0_last;
      end else if (acc1) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in1_data;
         out_last_d  = bus.in1_last;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
`ifndef MUX_STREAM_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
`ifndef MUX_STREAM_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign bus.in0_ready = in0_ready;
   assign bus.in1_ready = in1_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.sel       = sel_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_stream_arbiter.sv
// tb/tb_mux_stream_arbiter.sv - bench for mux_stream_arbiter with packet-order reference model
module tb_mux_stream_arbiter;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_stream_arbiter_if #(.DATA_W(DATA_W)) bus ();

   mux_stream_arbiter #(.DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_n  = 0;

   logic [8:0] src0[$];
   logic [8:0] src1[$];
   logic [8:0] exp_q[$];
   int         out_t[$];
   logic       first0, first1;
   int         gap_pct;
   int         hold0;
   bit         rnd_rdy;

   logic       s_ov, s_ol, s_busy, s_sel, s_r0, s_r1, s_acc0, s_acc1;
   logic [7:0] s_od;
   logic       prev_stall, prev_last;
   logic [7:0] prev_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic sample();
      logic [8:0] e;
      @(negedge clk);
      s_ov   = bus.out_valid;
      s_od   = bus.out_data;
      s_ol   = bus.out_last;
      s_busy = bus.busy;
      s_sel  = bus.sel;
      s_r0   = bus.in0_ready;
      s_r1   = bus.in1_ready;
      s_acc0 = bus.in0_valid && s_r0;
      s_acc1 = bus.in1_valid && s_r1;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         check("ready_onehot", 32'(s_r0 && s_r1), 0);
         if (prev_stall) begin
            check("stall_valid", 32'(s_ov), 1);
            check("stall_data", 32'(s_od), 32'(prev_data));
            check("stall_last", 32'(s_ol), 32'(prev_last));
         end
         if (s_acc0) begin
            check("sel_on_acc0", 32'(s_sel), 0);
            check("busy_on_acc0", 32'(s_busy), 1);
            if (src0.size() > 0) begin
               first0 = src0[0][8];
               void'(src0.pop_front());
            end
         end
         if (s_acc1) begin
            check("sel_on_acc1", 32'(s_sel), 1);
            check("busy_on_acc1", 32'(s_busy), 1);
            if (src1.size() > 0) begin
               first1 = src1[0][8];
               void'(src1.pop_front());
            end
         end
         if (s_ov && bus.out_ready) begin
            out_t.push_back(cyc_n);
            check("beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_data", 32'(s_od), 32'(e[7:0]));
               check("out_last", 32'(s_ol), 32'(e[8]));
            end
         end
         prev_stall = s_ov && !bus.out_ready;
         prev_data  = s_od;
         prev_last  = s_ol;
      end
   endtask

   task automatic drive();
      bus.in0_valid = (src0.size() > 0) && (hold0 == 0) &&
                      (first0 || ($urandom_range(0, 99) >= gap_pct));
      bus.in1_valid = (src1.size() > 0) &&
                      (first1 || ($urandom_range(0, 99) >= gap_pct));
      if (hold0 > 0) hold0--;
      bus.in0_data = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
      bus.in0_last = (src0.size() > 0) ? src0[0][8] : 1'b0;
      bus.in1_data = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
      bus.in1_last = (src1.size() > 0) ? src1[0][8] : 1'b0;
   endtask

   task automatic clear_inputs();
      bus.in0_valid = 1'b0; bus.in0_data = '0; bus.in0_last = 1'b0;
      bus.in1_valid = 1'b0; bus.in1_data = '0; bus.in1_last = 1'b0;
      src0.delete(); src1.delete(); exp_q.delete(); out_t.delete();
      first0 = 1'b1; first1 = 1'b1; hold0 = 0; gap_pct = 0; rnd_rdy = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(s_ov), 0);
      check({tag, "_out_data"}, 32'(s_od), 0);
      check({tag, "_out_last"}, 32'(s_ol), 0);
      check({tag, "_busy"}, 32'(s_busy), 0);
      check({tag, "_in0_ready"}, 32'(s_r0), 0);
      check({tag, "_in1_ready"}, 32'(s_r1), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      bus.out_ready = 1'b0;
      prev_stall = 1'b0;
      advance();
      advance();
      sample();
      check_idle_outputs("reset");
      check("reset_sel", 32'(s_sel), 0);
      advance();
      reset = 1'b0;
   endtask

   // Packet-level order: whole packets interleave; on contention the input
   // that did not go last wins (fixed build: input 0 always wins).
   task automatic model_order();
      logic [8:0] a0[$];
      logic [8:0] a1[$];
      logic [8:0] b;
      bit lg, pick;
      a0 = src0;
      a1 = src1;
      lg = 1'b1;
      while (a0.size() > 0 || a1.size() > 0) begin
         if (a0.size() > 0 && a1.size() > 0) begin
            pick = !lg;
`ifdef MUX_STREAM_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`endif
         end else begin
            pick = (a0.size() == 0);
         end
         do begin
            b = pick ? a1.pop_front() : a0.pop_front();
            exp_q.push_back(b);
         end while (!b[8]);
         lg = pick;
      end
   endtask

   task automatic gen_pkts(input int n);
      logic [7:0] d;
      int len;
      for (int p = 0; p < n; p++) begin
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            src0.push_back({b == len - 1, d});
         end
         len = $urandom_range(1, 4);
         for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            src1.push_back({b == len - 1, d});
         end
      end
   endtask

   task automatic pump(input int budget);
      for (int i = 0; i < budget && (exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0); i++) begin
         drive();
         bus.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         sample();
         advance();
      end
      check("drain", exp_q.size() + src0.size() + src1.size(), 0);
   endtask

   initial begin
      int c0, n0, n1, stall_n;
      bit b0, b1;

      reset = 1'b1;
      bus.out_ready = 1'b0;
      clear_inputs();

      // 3-beat packet on in0, exact latency and busy timing
      do_reset();
      bus.out_ready = 1'b1;
      src0 = '{9'h011, 9'h022, 9'h133};
      model_order();
      drive(); sample();
      check("t1_c0_busy", 32'(s_busy), 0);
      check("t1_c0_ready0", 32'(s_r0), 0);
      advance();
      drive(); sample();
      check("t1_c1_busy", 32'(s_busy), 1);
      check("t1_c1_sel", 32'(s_sel), 0);
      check("t1_c1_ready0", 32'(s_r0), 1);
      check("t1_c1_out_valid", 32'(s_ov), 0);
      advance();
      drive(); sample();
      check("t1_c2_out_valid", 32'(s_ov), 1);
      check("t1_c2_out_data", 32'(s_od), 32'h11);
      advance();
      drive(); sample();
      check("t1_c3_out_data", 32'(s_od), 32'h22);
      check("t1_c3_out_last", 32'(s_ol), 0);
      advance();
      drive(); sample();
      check("t1_c4_out_data", 32'(s_od), 32'h33);
      check("t1_c4_out_last", 32'(s_ol), 1);
      check("t1_c4_busy", 32'(s_busy), 0);
      advance();
      drive(); sample();
      check("t1_c5_out_valid", 32'(s_ov), 0);
      advance();
      check("t1_drain", exp_q.size(), 0);

      // Both inputs stream 2-beat packets continuously
      do_reset();
      bus.out_ready = 1'b1;
      for (int r = 0; r < 6; r++) begin
`ifdef MUX_STREAM_ARB_FIXED_PRIO_EN
         exp_q.push_back(9'h0A0); exp_q.push_back(9'h1A1);
`else
         if (r % 2 == 0) begin
            exp_q.push_back(9'h0A0); exp_q.push_back(9'h1A1);
         end else begin
            exp_q.push_back(9'h0B0); exp_q.push_back(9'h1B1);
         end
`endif
      end
      b0 = 1'b0; b1 = 1'b0;
      c0 = cyc_n;
      for (int i = 0; i < 60 && out_t.size() < 12; i++) begin
         bus.in0_valid = 1'b1; bus.in0_data = b0 ? 8'hA1 : 8'hA0; bus.in0_last = b0;
         bus.in1_valid = 1'b1; bus.in1_data = b1 ? 8'hB1 : 8'hB0; bus.in1_last = b1;
         sample();
         if (s_acc0) b0 = !b0;
         if (s_acc1) b1 = !b1;
         advance();
      end
      bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
      check("t2_drain", exp_q.size(), 0);
      check("t2_beats", out_t.size(), 12);
      for (int k = 0; k < 12 && k < out_t.size(); k++)
         check($sformatf("t2_beat%0d_cycle", k), out_t[k] - c0, 2 + 3 * (k / 2) + (k % 2));

      // in1 4-beat packet with a 3-cycle output stall
      do_reset();
      src1 = '{9'h061, 9'h062, 9'h063, 9'h164};
      model_order();
      stall_n = 0;
      for (int i = 0; i < 40 && (exp_q.size() > 0 || src1.size() > 0); i++) begin
         drive();
         bus.out_ready = (stall_n >= 3);
         sample();
         if (s_ov && stall_n < 3) begin
            check("t3_stall_data", 32'(s_od), 32'h61);
            check("t3_stall_ready1", 32'(s_r1), 0);
            stall_n++;
         end
         advance();
      end
      check("t3_stall_seen", stall_n, 3);
      check("t3_drain", exp_q.size() + src1.size(), 0);

      // in0 pauses mid-packet while in1 requests
      do_reset();
      bus.out_ready = 1'b1;
      src0 = '{9'h071, 9'h072, 9'h073, 9'h174};
      src1 = '{9'h181};
      model_order();
      n0 = 0;
      for (int i = 0; i < 40 && (exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0); i++) begin
         drive();
         sample();
         if (!bus.in0_valid && src0.size() > 0 && n0 > 0) begin
            check("t4_pause_ready1", 32'(s_r1), 0);
            check("t4_pause_sel", 32'(s_sel), 0);
            check("t4_pause_busy", 32'(s_busy), 1);
         end
         if (s_acc0) begin
            n0++;
            if (n0 == 1) hold0 = 2;
         end
         advance();
      end
      check("t4_drain", exp_q.size() + src0.size() + src1.size(), 0);

      // Single-beat packets on both inputs
      do_reset();
      src0 = '{9'h15A, 9'h15A};
      src1 = '{9'h1C3, 9'h1C3};
      model_order();
      pump(40);

      // Reset in the middle of an in1 packet
      do_reset();
      bus.out_ready = 1'b1;
      src0 = '{9'h155};
      src1 = '{9'h091, 9'h092, 9'h093, 9'h194};
      model_order();
      n1 = 0;
      for (int i = 0; i < 30 && n1 < 2; i++) begin
         drive();
         sample();
         if (s_acc1) n1++;
         advance();
      end
      check("t6_reached_mid", n1, 2);
      reset = 1'b1;
      drive();
      sample();
      advance();
      reset = 1'b0;
      clear_inputs();
      bus.out_ready = 1'b1;
      sample();
      check_idle_outputs("t6_after_reset");
      advance();
      src0 = '{9'h1E1};
      src1 = '{9'h1F1};
      exp_q.push_back(9'h1E1);
      exp_q.push_back(9'h1F1);
      pump(40);

      // Randomized packets, gaps and backpressure
      for (int r = 0; r < 3; r++) begin
         do_reset();
         gap_pct = r * 25;
         rnd_rdy = (r > 0);
         gen_pkts(6);
         model_order();
         pump(2000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_stream_arbiter.md
Name: mux_stream_arbiter

Overview:
- Two-requester packet arbiter sharing one output channel through a 2:1 select mux.
- Each input is a valid/ready stream with a `last` marker.
- The arbiter grants one input at a time in round-robin order.
- The grant is held for the whole packet; data is registered at the output.
- Sits in front of any single-consumer datapath fed by two producers.

Parameters:
- DATA_W, 8, width of each data path.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset; one clock, sampled on rising edge of clk.
- in0_valid  input  1  requester 0 beat valid.
- in0_data  input  DATA_W  requester 0 beat data.
- in0_last  input  1  requester 0 final beat of packet.
- in0_ready  output  1  requester 0 beat accepted when high with in0_valid.
- in1_valid  input  1  requester 1 beat valid.
- in1_data  input  DATA_W  requester 1 beat data.
- in1_last  input  1  requester 1 final beat of packet.
- in1_ready  output  1  requester 1 beat accepted when high with in1_valid.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered output data.
- out_last  output  1  registered output last marker.
- out_ready  input  1  downstream accepts beat when high with out_valid.
- sel  output  1  registered mux select, 0 = input 0, 1 = input 1; meaningful when busy=1.
- busy  output  1  high while a packet grant is held.

Behaviour:
- FSM states: IDLE, LOCK0, LOCK1. Reset state is IDLE.
- Registered state:
  - last_grant, reset value 1, so input 0 wins the first contention.
  - sel, reset value 0.
- Outputs during and after reset: out_valid=0, out_data=0, out_last=0, busy=0, in0_ready=0, in1_ready=0.
- IDLE arbitration:
  - Only in0_valid high -> LOCK0.
  - Only in1_valid high -> LOCK1.
  - Both high -> lock the input != last_grant.
  - Neither high -> stay in IDLE.
  - The decision is registered: on the IDLE->LOCKx transition, sel <= x and busy <= 1.
- Readiness:
  - In LOCKx: inx_ready = (!out_valid || out_ready).
  - The other input's ready is 0.
  - Both readies are 0 in IDLE.
  - Ready is combinational from state and output register; there is no path from in*_valid to in*_ready.
- Accept (inx_valid && inx_ready):
  - out_data <= inx_data, out_last <= inx_last, out_valid <= 1.
- No accept:
  - out_ready=1 -> out_valid <= 0; otherwise the output register holds.
- Accept with inx_last=1:
  - Next state is IDLE, last_grant <= x, busy <= 0.
  - sel holds its value.
- Timing:
  - Request in IDLE at cycle N -> grant visible at N+1 -> first beat accepted no earlier than N+1 -> out_valid no earlier than N+2.
  - Within a packet, throughput is 1 beat/cycle when out_ready=1.
  - Exactly one idle arbitration cycle separates consecutive packets.
- Backpressure:
  - out_valid=1 and out_ready=0 -> out_valid, out_data and out_last are stable; the locked input's ready is 0.
- Single-beat packet (valid with last on the first beat) -> LOCKx for exactly one accept cycle, then IDLE.
- Non-granted input: valid may stay high indefinitely. No beat from it is ever consumed or reordered into the current packet.
- Valid deassertion mid-packet: the lock is held (no timeout); the FSM waits in LOCKx.
- Reset mid-packet:
  - FSM -> IDLE, last_grant=1, output register cleared.
  - The in-flight packet is truncated; the upstream is responsible for resending.

Optional Feature:
- Macro: MUX_STREAM_ARB_FIXED_PRIO_EN.
- Defined: IDLE arbitration is fixed priority. Input 0 always wins when both are valid; last_grant is neither updated nor used.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then in0 sends a 3-beat packet (0x11, 0x22, 0x33 with last) and out_ready=1 -> sel=0; out beats 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after first valid; out_last only on 0x33; busy falls the cycle after the last accept.
- Both inputs present 2-beat packets continuously from reset (in0: 0xA0/0xA1, in1: 0xB0/0xB1) -> order out is A0, A1, B0, B1, A0, A1, ... with one bubble between packets; in the FIXED_PRIO_EN build the order is A0, A1, A0, A1 only.
- in1 streams 4 beats; out_ready held 0 for 3 cycles after the first out_valid -> out_data stays 0x…first beat, in1_ready=0 during the stall, and no beat is lost or duplicated.
- in0 packet in progress with in0_valid dropped for 2 cycles and in1_valid high -> in1_ready stays 0, sel stays 0, and the packet completes when in0 resumes.
- Single-beat packets on alternating inputs (0x5A on in0 with last, then 0xC3 on in1 with last) -> each output beat has out_last=1; the grant alternates.
- Reset asserted for 1 cycle in the middle of a 4-beat in1 packet -> next cycle out_valid=0, busy=0, both readies 0; a subsequent simultaneous request grants in0 first.
